// File: rtl/waitx2_sched_pkg.sv
// Shared types for the waitx2_sched wait-element sequencer.
package waitx2_sched_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StRelease,
    StDone
  } state_e;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_1    = 2'b01;
  localparam logic [1:0] WIN_2    = 2'b10;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for one asynchronous grant line.
module sync_ff #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[SYNC_STAGES-2:0], d_i};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= '0;
    else       sync_q <= sync_d;
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/waitx2_sched.sv
// Sequencer running 4-phase rounds on a two-input mutex wait element.
// Optional outcome counters are built when WAITX2_SCHED_STATS_EN is defined.
module waitx2_sched
  import waitx2_sched_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [TIMEOUT_W-1:0] timeout_cycles,
  output logic                 ctrl,
  input  logic                 g1,
  input  logic                 g2,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           winner,
  output logic                 timeout,
`ifdef WAITX2_SCHED_STATS_EN
  input  logic                 stats_clr,
  output logic [15:0]          win1_cnt,
  output logic [15:0]          win2_cnt,
  output logic [15:0]          tmo_cnt,
`endif
  output logic                 proto_err
);

  logic gs1, gs2;

  sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync_g1 (.clk_i(clk), .rst_i(rst), .d_i(g1), .q_o(gs1));
  sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync_g2 (.clk_i(clk), .rst_i(rst), .d_i(g2), .q_o(gs2));

  state_e               state_q, state_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 ctrl_q, ctrl_d, busy_q, busy_d, done_q, done_d;
  logic                 timeout_q, timeout_d, perr_q, perr_d;
  logic [1:0]           winner_q, winner_d;
  // Round outcome is held here until DONE so winner/timeout only change with done.
  logic [1:0]           res_win_q, res_win_d;
  logic                 res_tmo_q, res_tmo_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ctrl_d    = ctrl_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    winner_d  = winner_q;
    timeout_d = timeout_q;
    res_win_d = res_win_q;
    res_tmo_d = res_tmo_q;
    perr_d    = perr_q | (gs1 & gs2 & ((state_q == StArm) | (state_q == StRelease)));
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StArm;
          ctrl_d    = 1'b1;
          busy_d    = 1'b1;
          cnt_d     = '0;
          res_win_d = WIN_NONE;
          res_tmo_d = 1'b0;
        end
      end
      StArm: begin
        if (gs1 || gs2) begin
          res_win_d = (gs1 && !gs2) ? WIN_1 : (gs2 && !gs1) ? WIN_2 : WIN_NONE;
          state_d   = StRelease;
          ctrl_d    = 1'b0;
        end else if ((timeout_cycles != '0) && (cnt_q == timeout_cycles - TIMEOUT_W'(1))) begin
          res_tmo_d = 1'b1;
          state_d   = StRelease;
          ctrl_d    = 1'b0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + TIMEOUT_W'(1);
        end
      end
      StRelease: begin
        // Late grants after a timeout simply hold us here; the outcome is already fixed.
        if (!gs1 && !gs2) begin
          state_d   = StDone;
          done_d    = 1'b1;
          winner_d  = res_win_q;
          timeout_d = res_tmo_q;
        end
      end
      StDone: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      ctrl_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      winner_q  <= WIN_NONE;
      timeout_q <= 1'b0;
      res_win_q <= WIN_NONE;
      res_tmo_q <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ctrl_q    <= ctrl_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      winner_q  <= winner_d;
      timeout_q <= timeout_d;
      res_win_q <= res_win_d;
      res_tmo_q <= res_tmo_d;
      perr_q    <= perr_d;
    end
  end

  assign ctrl      = ctrl_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign winner    = winner_q;
  assign timeout   = timeout_q;
  assign proto_err = perr_q;

`ifdef WAITX2_SCHED_STATS_EN
  logic [15:0] win1_q, win1_d, win2_q, win2_d, tmo_q, tmo_d;

  always_comb begin
    win1_d = win1_q;
    win2_d = win2_q;
    tmo_d  = tmo_q;
    if (stats_clr) begin
      win1_d = '0;
      win2_d = '0;
      tmo_d  = '0;
    end else if (done_q) begin
      if ((winner_q == WIN_1) && (win1_q != '1)) win1_d = win1_q + 16'd1;
      if ((winner_q == WIN_2) && (win2_q != '1)) win2_d = win2_q + 16'd1;
      if (timeout_q && (tmo_q != '1))            tmo_d  = tmo_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win1_q <= '0;
      win2_q <= '0;
      tmo_q  <= '0;
    end else begin
      win1_q <= win1_d;
      win2_q <= win2_d;
      tmo_q  <= tmo_d;
    end
  end

  assign win1_cnt = win1_q;
  assign win2_cnt = win2_q;
  assign tmo_cnt  = tmo_q;
`endif

endmodule

// File: doc/waitx2_sched.md
Name: waitx2_sched

Overview:
- Clocked sequencer for a two-input mutual-exclusion wait element (sig1/sig2 arbiter with ctrl, g1, g2).
- Runs one 4-phase wait round per request: raises ctrl, synchronises the asynchronous grants, reports which input won, then releases ctrl and waits for both grants to return low.
- Enforces a timeout and flags protocol violations.
- Sits between the synchronous host logic and the asynchronous analog-interface element.

Parameters:
- SYNC_STAGES, 2, flop stages in each grant synchroniser (min 2).
- TIMEOUT_W, 16, width of timeout counter and of the timeout_cycles input.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request a wait round; sampled only in IDLE.
- timeout_cycles  in  TIMEOUT_W  max cycles in ARM; 0 disables timeout.
- ctrl  out  1  ctrl to the wait element.
- g1  in  1  grant 1 from the wait element (asynchronous).
- g2  in  1  grant 2 from the wait element (asynchronous).
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at end of round.
- winner  out  2  01 = sig1, 10 = sig2, 00 = none; valid with done, held until the next done.
- timeout  out  1  valid with done; round ended with no grant.
- proto_err  out  1  sticky; both grants seen high together. Cleared only by rst.

Behaviour:
- Reset: state IDLE; ctrl, busy, done, timeout, proto_err = 0; winner = 00; synchronisers and counter = 0.
- Grants pass through SYNC_STAGES flops to give gs1 and gs2. The FSM uses only gs1 and gs2.
- IDLE:
  - start=1 moves to ARM next cycle; ctrl=1 from that cycle on; counter loads 0.
  - start in any other state is ignored. It is not queued.
- ARM (ctrl=1):
  - gs1 & ~gs2: latch winner=01, go to RELEASE.
  - gs2 & ~gs1: latch winner=10, go to RELEASE.
  - gs1 & gs2: set proto_err, winner=00, go to RELEASE.
  - Otherwise increment the counter. If timeout_cycles≠0 and counter==timeout_cycles-1: set timeout flag, winner=00, go to RELEASE.
- RELEASE (ctrl=0):
  - Wait until gs1=0 and gs2=0 in the same cycle, then go to DONE.
  - A grant arriving here after a timeout (late race) is absorbed; winner stays 00 and timeout stays 1.
  - gs1 & gs2 seen here also sets proto_err.
- DONE: done=1 for one cycle, then IDLE. busy drops in the same cycle as the return to IDLE.
- Latency:
  - start to ctrl rise: 1 cycle.
  - A grant already high when ctrl rises reaches ARM decision after SYNC_STAGES cycles; ctrl drops the cycle after.
- Counter saturates and never wraps. Timeout comparison is unsigned.
- rst mid-round: ctrl drops immediately (async); all state is lost.
- An element that keeps a grant high makes the block hang in RELEASE by design; the host detects this via busy.

Optional Feature:
- Macro: WAITX2_SCHED_STATS_EN.
- Defined: adds outputs win1_cnt, win2_cnt, tmo_cnt (each 16 bit, saturating).
  - Each increments on a done pulse with the matching outcome.
  - Input stats_clr (1 bit) zeroes all three synchronously; clear wins over a same-cycle increment.
- Not defined: these ports and registers do not exist; the rest of the behaviour is identical.

Decomposition:
- Package waitx2_sched_pkg holds:
  - state enum (IDLE, ARM, RELEASE, DONE);
  - winner encodings WIN_NONE=2'b00, WIN_1=2'b01, WIN_2=2'b10.
- Sub-module: sync_ff (parameterised SYNC_STAGES, async-high reset), instantiated once per grant.

Test Plan:
- Basic win on 1: start pulse; g1 rises 5 cycles after ctrl, falls 3 cycles after ctrl falls. Expect:
  - ctrl high 1 cycle after start;
  - ctrl low 3 cycles after g1 rise;
  - done with winner=01, timeout=0;
  - busy low the cycle after done.
- Basic win on 2: same sequence on g2. Expect winner=10.
- Timeout: timeout_cycles=10, no grants. Expect ctrl high exactly 10 cycles, then done with timeout=1, winner=00.
- Late race: timeout_cycles=4; g1 rises 1 cycle after ctrl falls and falls 6 cycles later. Expect:
  - done only after gs1 low;
  - winner=00, timeout=1.
- Protocol error: g1 and g2 rise together. Expect:
  - proto_err=1, winner=00;
  - done after both low;
  - proto_err still 1 after the next clean round.
- Reset mid-ARM: assert rst 3 cycles into ARM. Expect ctrl=0 asynchronously and all outputs at reset values; start after rst release begins a clean round.
- With WAITX2_SCHED_STATS_EN: 3 wins on 1, 2 timeouts, then stats_clr in the same cycle as a done. Expect win1_cnt=3 and tmo_cnt=2 before the clear, and all counters 0 after it.
